ofm_stream_checker: RTL and testbench

- Synthesizable, parametrised successor to the bench-side output check of the convolution kernel.
- Watches the kernel's output write stream (`o_wren`/`o_addr`/`o_din`) and reads a golden-result RAM with 1-cycle read latency.
- Compares every write, counts mismatches, captures the first failure, and reports completion, pass/fail and watchdog timeout.
- Sits beside the CNN core on-chip, so FPGA self-test runs need no simulator file I/O.

---
 rtl/ofm_stream_checker.sv | 133 +++++++++++++
 tb/tb_ofm_stream_checker.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ofm_stream_checker.sv
// On-chip checker for the convolution kernel's output write stream against a golden RAM (1-cycle read).
// Optional per-channel error bitmap is built when CHK_PER_CHANNEL_EN is defined.
module ofm_stream_checker #(
  parameter int DATA_W  = 25,
  parameter int ADDR_W  = 32,
  parameter int M       = 8,
  parameter int ROUT    = 61,
  parameter int COUT    = 61,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              o_wren,
  input  logic [ADDR_W-1:0] o_addr,
  input  logic [DATA_W-1:0] o_din,
  output logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] out_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_got,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [M-1:0]      err_ch_map
);
  localparam int TOTAL = M * ROUT * COUT;
  localparam int CH_SZ = ROUT * COUT;
  localparam int IW    = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] TOTAL_A   = ADDR_W'(TOTAL);
  localparam logic [IW-1:0]     IDLE_LAST = IW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, state_nxt;

  logic              accept, s1_vld, s1_oor, s1_err, last_cmp, wd_fire;
  logic [ADDR_W-1:0] s1_addr;
  logic [DATA_W-1:0] s1_data, s1_exp;
  logic [IW-1:0]     idle_cnt;

  assign accept   = (state == S_RUN) && o_wren && !start;
  assign exp_addr = accept ? o_addr : '0;
  // Out-of-range writes have no golden word; they always count as errors with expected 0.
  assign s1_oor   = s1_addr >= TOTAL_A;
  assign s1_exp   = s1_oor ? '0 : exp_rdata;
  assign s1_err   = s1_vld && (s1_oor || (s1_data != exp_rdata));
  assign last_cmp = s1_vld && (out_cnt == TOTAL_A);
  assign wd_fire  = (state == S_RUN) && !start && !accept && (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (start) state_nxt = S_RUN;
               else if (last_cmp || wd_fire) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
    pass = (state == S_DONE) && (err_cnt == '0) && !timeout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld         <= 1'b0;
      s1_addr        <= '0;
      s1_data        <= '0;
      out_cnt        <= '0;
      idle_cnt       <= '0;
      timeout        <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_err_got  <= '0;
      first_err_exp  <= '0;
    end else if (start) begin
      // A compare in flight on the start cycle is dropped with the rest of the old run.
      s1_vld         <= 1'b0;
      out_cnt        <= '0;
      idle_cnt       <= '0;
      timeout        <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_err_got  <= '0;
      first_err_exp  <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_addr <= o_addr;
        s1_data <= o_din;
        out_cnt <= out_cnt + 1'b1;
      end
      if (state == S_RUN) idle_cnt <= accept ? '0 : idle_cnt + 1'b1;
      if (wd_fire) timeout <= 1'b1;
      if (s1_err) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        if (err_cnt == '0) begin
          first_err_addr <= s1_addr;
          first_err_got  <= s1_data;
          first_err_exp  <= s1_exp;
        end
      end
    end
  end

`ifdef CHK_PER_CHANNEL_EN
  logic [M-1:0] ch_hit;
  for (genvar g = 0; g < M; g++) begin : g_ch
    localparam logic [ADDR_W-1:0] LO = ADDR_W'(g * CH_SZ);
    localparam logic [ADDR_W-1:0] HI = ADDR_W'((g + 1) * CH_SZ);
    assign ch_hit[g] = (s1_addr >= LO) && (s1_addr < HI);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_ch_map <= '0;
    else if (start)  err_ch_map <= '0;
    else if (s1_err) err_ch_map <= err_ch_map | ch_hit;
  end
`else
  assign err_ch_map = '0;
`endif
endmodule

// File: tb/tb_ofm_stream_checker.sv
// Directed + randomized bench for ofm_stream_checker with a golden RAM and a write-list result model.
module tb_ofm_stream_checker;
  localparam int DW = 25, AW = 32, M = 2, R = 2, C = 2, TO = 16, TOTAL = M * R * C;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, o_wren = 1'b0;
  logic [AW-1:0] o_addr = '0;
  logic [DW-1:0] o_din = '0;
  logic [AW-1:0] exp_addr, out_cnt, first_err_addr;
  logic [DW-1:0] exp_rdata, first_err_got, first_err_exp;
  logic          busy, done, pass, timeout;
  logic [15:0]   err_cnt;
  logic [M-1:0]  err_ch_map;

  ofm_stream_checker #(.DATA_W(DW), .ADDR_W(AW), .M(M), .ROUT(R), .COUT(C), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .o_wren(o_wren), .o_addr(o_addr), .o_din(o_din),
    .exp_addr(exp_addr), .exp_rdata(exp_rdata), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_cnt(err_cnt), .out_cnt(out_cnt), .first_err_addr(first_err_addr),
    .first_err_got(first_err_got), .first_err_exp(first_err_exp), .err_ch_map(err_ch_map));

  always #5 clk = ~clk;

  logic [DW-1:0] gold [TOTAL];
  always @(posedge clk) begin
    logic [AW-1:0] ra;
    ra = exp_addr;
    exp_rdata <= (ra < TOTAL) ? gold[ra[2:0]] : 25'h1ABCDE;
  end

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t q[$];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    o_wren = 1'b1; o_addr = a; o_din = d; cyc(); o_wren = 1'b0;
  endtask

  task automatic send_q(input int gapmax);
    foreach (q[i]) begin
      wr(q[i].a, q[i].d);
      if (gapmax > 0 && i != q.size() - 1) repeat ($urandom_range(0, gapmax)) cyc();
    end
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w; w.a = a; w.d = d; q.push_back(w);
  endtask

  task automatic clean_q();
    q.delete();
    for (int i = 0; i < TOTAL; i++) push(i, gold[i]);
  endtask

  // Expected results from the list of accepted writes since the last start.
  task automatic check_model(input string tag, input bit exp_done, input bit exp_to);
    int e = 0;
    logic [AW-1:0] fa = '0;
    logic [DW-1:0] fg = '0, fe = '0, ev;
    logic [M-1:0] map = '0;
    foreach (q[i]) begin
      logic [AW-1:0] a;
      a = q[i].a;
      ev = (a < TOTAL) ? gold[a[2:0]] : '0;
      if (a >= TOTAL || q[i].d != ev) begin
        if (e == 0) begin fa = a; fg = q[i].d; fe = ev; end
        e++;
        if (a < TOTAL) map[a / (R * C)] = 1'b1;
      end
    end
`ifndef CHK_PER_CHANNEL_EN
    map = '0;
`endif
    chk({tag, ".done"}, done, exp_done);
    chk({tag, ".timeout"}, timeout, exp_to);
    chk({tag, ".pass"}, pass, exp_done && e == 0 && !exp_to);
    chk({tag, ".err_cnt"}, err_cnt, e);
    chk({tag, ".out_cnt"}, out_cnt, q.size());
    chk({tag, ".first_addr"}, first_err_addr, fa);
    chk({tag, ".first_got"}, first_err_got, fg);
    chk({tag, ".first_exp"}, first_err_exp, fe);
    chk({tag, ".ch_map"}, err_ch_map, map);
  endtask

  task automatic finish_run(input string tag);
    smp(); chk({tag, ".done_early"}, done, 1'b0);
    cyc(); smp(); check_model(tag, 1'b1, 1'b0);
  endtask

  initial begin
    foreach (gold[i]) gold[i] = DW'($urandom);
    gold[5] = 25'h7;

    // reset state
    repeat (2) cyc();
    smp();
    q.delete();
    check_model("reset", 1'b0, 1'b0);
    chk("reset.busy", busy, 1'b0);
    chk("reset.exp_addr", exp_addr, 0);
    rst_n = 1'b1;
    cyc();

    // T5: writes in IDLE and on start cycles are ignored; mid-run restart clears everything
    wr(0, gold[0]);
    o_wren = 1'b1; start = 1'b1; cyc(); start = 1'b0; o_wren = 1'b0;
    smp(); chk("t5.idle_ign", out_cnt, 0); chk("t5.busy", busy, 1'b1);
    for (int i = 0; i < 4; i++) wr(i, (i == 3) ? ~gold[3] : gold[i]);
    o_wren = 1'b1; o_addr = 4; o_din = ~gold[4]; start = 1'b1; cyc(); start = 1'b0; o_wren = 1'b0;
    smp(); chk("t5.restart_out", out_cnt, 0); chk("t5.restart_err", err_cnt, 0);
    chk("t5.restart_busy", busy, 1'b1);
    clean_q(); send_q(0); finish_run("t5");

    // T1: clean back-to-back run
    pulse_start(); clean_q(); send_q(0); finish_run("t1");

    // T2: two mismatches (addr 5 got 3 exp 7, addr 6)
    pulse_start(); clean_q(); q[5].d = 25'h3; q[6].d = gold[6] ^ 25'h10000;
    send_q(0); finish_run("t2");
    chk("t2.first_got3", first_err_got, 25'h3); chk("t2.first_exp7", first_err_exp, 25'h7);

    // T4: out-of-range address
    pulse_start(); q.delete(); push(9, 25'h155);
    send_q(0); cyc(); smp();
    check_model("t4", 1'b0, 1'b0);

    // T3: watchdog after 3 writes
    pulse_start(); q.delete();
    for (int i = 0; i < 3; i++) push(i, gold[i]);
    send_q(0);
    repeat (15) cyc();
    smp(); chk("t3.done_early", done, 1'b0);
    cyc(); smp(); check_model("t3", 1'b1, 1'b1);

    // randomized runs with gaps, corruption and out-of-range addresses
    for (int r = 0; r < 6; r++) begin
      pulse_start(); q.delete();
      for (int i = 0; i < TOTAL; i++) begin
        logic [AW-1:0] a;
        a = $urandom_range(0, 9);
        push(a, (a < TOTAL && $urandom_range(0, 2) != 0) ? gold[a[2:0]] : DW'($urandom));
      end
      send_q(3); finish_run("rand");
    end

    // T6: async reset mid-run between edges
    pulse_start(); q.delete();
    wr(1, ~gold[1]); wr(2, gold[2]); cyc();
    smp(); chk("t6.pre_err", err_cnt, 1);
    cyc();
    o_wren = 1'b1; o_addr = 5; o_din = gold[5];
    #1 rst_n = 1'b0;
    #2;
    check_model("t6.async", 1'b0, 1'b0);
    chk("t6.busy", busy, 1'b0); chk("t6.exp_addr", exp_addr, 0);
    #1 rst_n = 1'b1;
    cyc(); wr(0, gold[0]); wr(1, gold[1]);
    smp(); chk("t6.ign_out", out_cnt, 0); chk("t6.ign_busy", busy, 1'b0);
    pulse_start(); clean_q(); send_q(0); finish_run("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
